// File: rtl/calc_pkg.sv
// Shared calculator-datapath types and limits for the keypad entry path.
// Digits are BCD nibbles; the Horner accumulator is 14 bits wide because 9999 fits in 14 bits.
package calc_pkg;

  localparam int MAX_DIGITS = 4;
  localparam int MAX_MAG    = 9999;
  localparam int ACC_W      = 14;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    CONV  = 2'd2,
    DONE  = 2'd3
  } dig2bin_state_t;

endpackage

// File: rtl/bcd_horner_step.sv
// One Horner step for the keypad converter: o_acc = i_acc*10 + i_digit.
// The multiply by ten is built as (acc<<3) + (acc<<1).
module bcd_horner_step
  import calc_pkg::*;
(
  input  logic [ACC_W-1:0] i_acc,
  input  bcd_t             i_digit,
  output logic [ACC_W-1:0] o_acc
);

  assign o_acc = (i_acc << 3) + (i_acc << 1) + {{(ACC_W-4){1'b0}}, i_digit};

endmodule

// File: rtl/dig2bin.sv
// Keypad-entry accumulator: up to four BCD digits and a sign, then a four-cycle Horner conversion.
// Optional macro DIG2BIN_BACKSPACE_EN enables the backspace strobe; without it, backspace is ignored.
module dig2bin #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        neg_toggle,
  input  logic        backspace,
  input  logic        clear,
  input  logic        commit,
  output logic [3:0]  D3,
  output logic [3:0]  D2,
  output logic [3:0]  D1,
  output logic [3:0]  D0,
  output logic        NEG,
  output logic [2:0]  count,
  output logic        busy,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        digit_err
);
  import calc_pkg::*;

  dig2bin_state_t   r_state, w_state_next;
  logic [3:0][3:0]  r_d, w_d_next;
  logic             r_neg, w_neg_next;
  logic [2:0]       r_count, w_count_next;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [1:0]       r_step, w_step_next;
  logic [15:0]      r_value, w_value_next;
  logic             r_vv, w_vv_next;
  logic             r_err, w_err_next;

  logic             w_bs;
  bcd_t             w_cur_digit;
  logic [ACC_W-1:0] w_horner;
  logic [15:0]      w_mag;
  logic [15:0]      w_signed;

`ifdef DIG2BIN_BACKSPACE_EN
  assign w_bs = backspace;
`else
  assign w_bs = backspace & 1'b0;
`endif

  // Step 0 consumes D3 (most significant), step 3 consumes D0.
  assign w_cur_digit = r_d[2'd3 - r_step];

  bcd_horner_step u_step (
    .i_acc   (r_acc),
    .i_digit (w_cur_digit),
    .o_acc   (w_horner)
  );

  assign w_mag    = {{(16-ACC_W){1'b0}}, w_horner};
  assign w_signed = r_neg ? (16'd0 - w_mag) : w_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_d     <= '0;
      r_neg   <= 1'b0;
      r_count <= 3'd0;
      r_acc   <= '0;
      r_step  <= 2'd0;
      r_value <= 16'd0;
      r_vv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_d     <= w_d_next;
      r_neg   <= w_neg_next;
      r_count <= w_count_next;
      r_acc   <= w_acc_next;
      r_step  <= w_step_next;
      r_value <= w_value_next;
      r_vv    <= w_vv_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_d_next     = r_d;
    w_neg_next   = r_neg;
    w_count_next = r_count;
    w_acc_next   = r_acc;
    w_step_next  = r_step;
    w_value_next = r_value;
    w_vv_next    = 1'b0;
    w_err_next   = 1'b0;

    if (r_state == CONV) begin
      w_acc_next  = w_horner;
      w_step_next = r_step + 2'd1;
      if (r_step == 2'd3) begin
        w_value_next = w_signed;
        w_vv_next    = 1'b1;
        w_state_next = DONE;
        // A zero magnitude never reports as negative.
        if (w_horner == '0) w_neg_next = 1'b0;
      end
    end else if (clear) begin
      w_d_next     = '0;
      w_neg_next   = 1'b0;
      w_count_next = 3'd0;
      w_state_next = EMPTY;
    end else if (commit) begin
      w_acc_next   = '0;
      w_step_next  = 2'd0;
      w_state_next = CONV;
    end else if (w_bs) begin
      w_d_next     = {4'd0, r_d[3:1]};
      w_count_next = (r_count == 3'd0) ? 3'd0 : r_count - 3'd1;
      w_state_next = (r_count <= 3'd1) ? EMPTY : ENTRY;
    end else if (neg_toggle) begin
      w_neg_next = ~r_neg;
      if (r_state == DONE) w_state_next = ENTRY;
    end else if (digit_valid) begin
      if (digit > 4'd9) begin
        w_err_next = 1'b1;
      end else if (r_state == DONE) begin
        // A new key after a result starts a fresh operand.
        w_d_next     = {12'd0, digit};
        w_neg_next   = 1'b0;
        w_count_next = 3'd1;
        w_state_next = ENTRY;
      end else if (r_count == 3'(MAX_DIGITS)) begin
        w_err_next = 1'b1;
      end else begin
        w_d_next     = {r_d[2:0], digit};
        w_count_next = r_count + 3'd1;
        w_state_next = ENTRY;
      end
    end
  end

  assign D3          = r_d[3];
  assign D2          = r_d[2];
  assign D1          = r_d[1];
  assign D0          = r_d[0];
  assign NEG         = r_neg;
  assign count       = r_count;
  assign busy        = (r_state == CONV);
  assign value       = r_value;
  assign value_valid = r_vv;
  assign digit_err   = r_err;

endmodule

// File: tb/tb_dig2bin.sv
// Testbench for dig2bin: directed vector table, hand sequences for backspace and mid-conversion
// reset, then randomized strobes checked every cycle against an integer/queue reference model.
module tb_dig2bin;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        neg_toggle = 1'b0;
  logic        backspace = 1'b0;
  logic        clear = 1'b0;
  logic        commit = 1'b0;
  logic [3:0]  D3, D2, D1, D0;
  logic        NEG;
  logic [2:0]  count;
  logic        busy;
  logic [15:0] value;
  logic        value_valid;
  logic        digit_err;

  always #5 clk = ~clk;

  dig2bin dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .neg_toggle  (neg_toggle),
    .backspace   (backspace),
    .clear       (clear),
    .commit      (commit),
    .D3          (D3),
    .D2          (D2),
    .D1          (D1),
    .D0          (D0),
    .NEG         (NEG),
    .count       (count),
    .busy        (busy),
    .value       (value),
    .value_valid (value_valid),
    .digit_err   (digit_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [38:0] got;
  assign got = {D3, D2, D1, D0, NEG, count, busy, value, value_valid, digit_err};

  typedef struct {
    bit          clr, cmt, bs, ng, dv;
    logic [3:0]  dg;
    logic [38:0] exp;
  } vec_t;
  vec_t tbl[$];

`ifdef DIG2BIN_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  // Reference model: digits as an integer list (oldest first), plus sign and conversion countdown.
  int   m_q[$];
  bit   m_neg, m_done, m_vv, m_err;
  int   m_conv, m_value;
  bit   model_on = 1'b0;

  function automatic string fmt(input logic [38:0] x);
    return $sformatf("D=%h neg=%b cnt=%0d busy=%b val=%h vv=%b err=%b",
                     x[38:23], x[22], x[21:19], x[18], x[17:2], x[1], x[0]);
  endfunction

  task automatic check_all(input string name, input logic [38:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %s, want %s", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int g, input int e);
    n_cmp++;
    if (g != e) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, g, e);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_neg = 0; m_done = 0; m_vv = 0; m_err = 0; m_conv = 0; m_value = 0;
  endtask

  task automatic model_step(input bit clr, cmt, bs, ng, dv, input int dg);
    int mag;
    bit bs_eff;
    bs_eff = bs && BS_EN;
    m_vv = 0;
    m_err = 0;
    if (m_conv > 0) begin
      m_conv--;
      if (m_conv == 0) begin
        mag = 0;
        foreach (m_q[i]) mag = mag * 10 + m_q[i];
        if (mag == 0) m_neg = 0;
        m_value = m_neg ? -mag : mag;
        m_vv = 1;
        m_done = 1;
      end
    end else if (clr) begin
      m_q.delete(); m_neg = 0; m_done = 0;
    end else if (cmt) begin
      m_conv = 4; m_done = 0;
    end else if (bs_eff) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
      m_done = 0;
    end else if (ng) begin
      m_neg = ~m_neg; m_done = 0;
    end else if (dv) begin
      if (dg > 9) m_err = 1;
      else if (m_done) begin
        m_q.delete(); m_neg = 0; m_q.push_back(dg); m_done = 0;
      end else if (m_q.size() == 4) m_err = 1;
      else m_q.push_back(dg);
    end
  endtask

  function automatic logic [38:0] model_exp();
    logic [15:0] d;
    logic [15:0] v;
    int          sz;
    int          nib;
    d  = 16'd0;
    sz = m_q.size();
    for (int k = 0; k < 4; k++) begin
      nib = (k < sz) ? m_q[sz-1-k] : 0;
      d[4*k +: 4] = nib[3:0];
    end
    v = m_value[15:0];
    return {d, m_neg, 3'(sz), (m_conv > 0), v, m_vv, m_err};
  endfunction

  task automatic drive(input bit clr, cmt, bs, ng, dv, input logic [3:0] dg);
    @(negedge clk);
    clear = clr; commit = cmt; backspace = bs; neg_toggle = ng; digit_valid = dv; digit = dg;
    @(posedge clk);
    if (model_on) model_step(clr, cmt, bs, ng, dv, int'(dg));
    #1;
    clear = 0; commit = 0; backspace = 0; neg_toggle = 0; digit_valid = 0; digit = 4'd0;
  endtask

  task automatic add(input bit clr, cmt, bs, ng, dv, input logic [3:0] dg,
                     input logic [15:0] ed, input bit en, input logic [2:0] ec, input bit eb,
                     input logic [15:0] ev, input bit evv, input bit ee);
    vec_t t;
    t.clr = clr; t.cmt = cmt; t.bs = bs; t.ng = ng; t.dv = dv; t.dg = dg;
    t.exp = {ed, en, ec, eb, ev, evv, ee};
    tbl.push_back(t);
  endtask

  task automatic add_busy(input int n, input logic [15:0] ed, input bit en, input logic [2:0] ec,
                          input logic [15:0] ev);
    for (int i = 0; i < n; i++) add(0,0,0,0,0,4'd0, ed, en, ec, 1, ev, 0, 0);
  endtask

  initial begin
    int vv_seen;
    int exp_cnt;

    // 1234 conversion
    add(0,0,0,0,1,4'd1, 16'h0001,0,3'd1,0,16'h0000,0,0);
    add(0,0,0,0,1,4'd2, 16'h0012,0,3'd2,0,16'h0000,0,0);
    add(0,0,0,0,1,4'd3, 16'h0123,0,3'd3,0,16'h0000,0,0);
    add(0,0,0,0,1,4'd4, 16'h1234,0,3'd4,0,16'h0000,0,0);
    add(0,1,0,0,0,4'd0, 16'h1234,0,3'd4,1,16'h0000,0,0);
    add_busy(3, 16'h1234, 0, 3'd4, 16'h0000);
    add(0,0,0,0,0,4'd0, 16'h1234,0,3'd4,0,16'h04D2,1,0);
    add(0,0,0,0,0,4'd0, 16'h1234,0,3'd4,0,16'h04D2,0,0);
    // -50
    add(0,0,0,0,1,4'd5, 16'h0005,0,3'd1,0,16'h04D2,0,0);
    add(0,0,0,0,1,4'd0, 16'h0050,0,3'd2,0,16'h04D2,0,0);
    add(0,0,0,1,0,4'd0, 16'h0050,1,3'd2,0,16'h04D2,0,0);
    add(0,1,0,0,0,4'd0, 16'h0050,1,3'd2,1,16'h04D2,0,0);
    add_busy(3, 16'h0050, 1, 3'd2, 16'h04D2);
    add(0,0,0,0,0,4'd0, 16'h0050,1,3'd2,0,16'hFFCE,1,0);
    // negative zero
    add(1,0,0,0,0,4'd0, 16'h0000,0,3'd0,0,16'hFFCE,0,0);
    add(0,0,0,1,0,4'd0, 16'h0000,1,3'd0,0,16'hFFCE,0,0);
    add(0,1,0,0,0,4'd0, 16'h0000,1,3'd0,1,16'hFFCE,0,0);
    add_busy(3, 16'h0000, 1, 3'd0, 16'hFFCE);
    add(0,0,0,0,0,4'd0, 16'h0000,0,3'd0,0,16'h0000,1,0);
    // illegal key code, then -9999 with a rejected fifth digit
    add(0,0,0,0,1,4'hA, 16'h0000,0,3'd0,0,16'h0000,0,1);
    add(0,0,0,0,0,4'd0, 16'h0000,0,3'd0,0,16'h0000,0,0);
    add(0,0,0,0,1,4'd9, 16'h0009,0,3'd1,0,16'h0000,0,0);
    add(0,0,0,0,1,4'd9, 16'h0099,0,3'd2,0,16'h0000,0,0);
    add(0,0,0,0,1,4'd9, 16'h0999,0,3'd3,0,16'h0000,0,0);
    add(0,0,0,0,1,4'd9, 16'h9999,0,3'd4,0,16'h0000,0,0);
    add(0,0,0,0,1,4'd5, 16'h9999,0,3'd4,0,16'h0000,0,1);
    add(0,0,0,0,1,4'hA, 16'h9999,0,3'd4,0,16'h0000,0,1);
    add(0,0,0,1,0,4'd0, 16'h9999,1,3'd4,0,16'h0000,0,0);
    add(0,1,0,0,0,4'd0, 16'h9999,1,3'd4,1,16'h0000,0,0);
    add_busy(3, 16'h9999, 1, 3'd4, 16'h0000);
    add(0,0,0,0,0,4'd0, 16'h9999,1,3'd4,0,16'hD8F1,1,0);
    // commit+clear: clear wins; clear during conversion is dropped
    add(1,0,0,0,0,4'd0, 16'h0000,0,3'd0,0,16'hD8F1,0,0);
    add(0,0,0,0,1,4'd7, 16'h0007,0,3'd1,0,16'hD8F1,0,0);
    add(1,1,0,0,0,4'd0, 16'h0000,0,3'd0,0,16'hD8F1,0,0);
    add(0,0,0,0,1,4'd3, 16'h0003,0,3'd1,0,16'hD8F1,0,0);
    add(0,1,0,0,0,4'd0, 16'h0003,0,3'd1,1,16'hD8F1,0,0);
    add(1,0,0,0,0,4'd0, 16'h0003,0,3'd1,1,16'hD8F1,0,0);
    add_busy(2, 16'h0003, 0, 3'd1, 16'hD8F1);
    add(0,0,0,0,0,4'd0, 16'h0003,0,3'd1,0,16'h0003,1,0);
    // neg beats digit; commit beats neg and digit; digit during conversion ignored
    add(0,0,0,1,1,4'd4, 16'h0003,1,3'd1,0,16'h0003,0,0);
    add(0,1,0,1,1,4'd4, 16'h0003,1,3'd1,1,16'h0003,0,0);
    add(0,0,0,0,1,4'd8, 16'h0003,1,3'd1,1,16'h0003,0,0);
    add_busy(2, 16'h0003, 1, 3'd1, 16'h0003);
    add(0,0,0,0,0,4'd0, 16'h0003,1,3'd1,0,16'hFFFD,1,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_state", 39'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].cmt, tbl[i].bs, tbl[i].ng, tbl[i].dv, tbl[i].dg);
      check_all($sformatf("vec%0d", i), tbl[i].exp);
      $display("vec %0d: %s", i, fmt(got));
    end

    // Backspace: keys 1,2,3, backspace, commit
    drive(1,0,0,0,0,4'd0);
    drive(0,0,0,0,1,4'd1);
    drive(0,0,0,0,1,4'd2);
    drive(0,0,0,0,1,4'd3);
    drive(0,0,1,0,0,4'd0);
    exp_cnt = BS_EN ? 2 : 3;
    check_int("bs_count", int'(count), exp_cnt);
    drive(0,1,0,0,0,4'd0);
    repeat (4) drive(0,0,0,0,0,4'd0);
    check_int("bs_value", int'($signed(value)), BS_EN ? 12 : 123);
    check_int("bs_vv", int'(value_valid), 1);
    $display("backspace seq: value=%0d count=%0d", $signed(value), count);
    // Backspace beats neg_toggle when enabled; ignored otherwise
    drive(0,0,1,1,0,4'd0);
    check_int("bs_neg_prio", int'({NEG, count}), BS_EN ? 1 : (8 + 3));

    // Reset asserted during the second conversion cycle
    drive(1,0,0,0,0,4'd0);
    drive(0,0,0,0,1,4'd7);
    drive(0,1,0,0,0,4'd0);
    drive(0,0,0,0,0,4'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all("rst_midconv_async", 39'd0);
    vv_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (value_valid) vv_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      drive(0,0,0,0,0,4'd0);
      if (value_valid) vv_seen++;
    end
    check_int("rst_midconv_no_vv", vv_seen, 0);
    check_all("rst_midconv_after", 39'd0);
    $display("reset mid-conversion: value=%h vv_seen=%0d", value, vv_seen);

    // Randomized strobes against the reference model
    model_reset();
    model_on = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      bit         r_clr, r_cmt, r_bs, r_ng, r_dv;
      logic [3:0] r_dg;
      r_dv  = ($urandom_range(0, 99) < 50);
      r_ng  = ($urandom_range(0, 99) < 8);
      r_cmt = ($urandom_range(0, 99) < 7);
      r_clr = ($urandom_range(0, 99) < 3);
      r_bs  = ($urandom_range(0, 99) < 8);
      r_dg  = 4'($urandom_range(0, 11));
      drive(r_clr, r_cmt, r_bs, r_ng, r_dv, r_dg);
      check_all($sformatf("rand%0d", i), model_exp());
      if (m_vv) $display("rand %0d: conversion value=%0d got=%0d", i, m_value, $signed(value));
    end
    model_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
